nco_out_serializer: RTL and testbench
=====================================

Name: nco_out_serializer

Overview:
- Downstream of the NCO top. Captures each 12-bit X/Y sample pair the NCO presents on its valid strobes.
- Buffers the pairs in a small FIFO, then ships each pair off-chip as a 6-nibble frame over a 4-bit pad bus with a valid/ready handshake.
- Lets the NCO run at full rate while the pad interface is narrow and may stall.

Parameters:
- DEPTH, 4, FIFO entries (sample pairs); power of two, minimum 2.
- NW, 4, nibble width in bits; fixed at 4, so 12/NW = 3 nibbles per component.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- VldX  in  1  X sample valid, from NCO.
- VldY  in  1  Y sample valid, from NCO.
- inX  in  12  X sample (cosine).
- inY  in  12  Y sample (sine).
- Rdy  in  1  pad-side consumer ready.
- Dout  out  4  current nibble.
- Vld  out  1  Dout valid.
- Sof  out  1  high with the first nibble of a frame.
- Eof  out  1  high with the last nibble of a frame.
- Ovf  out  1  sticky: a sample pair was dropped because the FIFO was full.
- SyncErr  out  1  sticky: VldX and VldY disagreed in some cycle.

Behaviour:
- Reset (rst high at clock edge):
  - FIFO emptied; read and write pointers = 0.
  - FSM to IDLE; nibble index = 0.
  - Dout=0, Vld=0, Sof=0, Eof=0, Ovf=0, SyncErr=0.
  - Reset mid-frame abandons the frame. No partial frame is resumed.
- Capture:
  - In a cycle with VldX&VldY=1, {inX,inY} (24 bits) is written at that edge if the FIFO is not full.
  - VldX^VldY=1: nothing written; SyncErr set.
- Full:
  - Capture while full with no pop in the same cycle: pair dropped, Ovf set.
  - Capture while full with a pop in the same cycle: the pop frees a slot, the pair is written, Ovf unchanged.
- Sticky flags clear only on rst.
- FIFO: circular buffer, pointers wrap at DEPTH, with an occupancy count 0..DEPTH. Full = count==DEPTH; empty = count==0.
- FSM IDLE:
  - Vld=0.
  - If the FIFO is non-empty, at the edge: pop the head into a 24-bit shift register, Vld=1, Dout=X[11:8], Sof=1, index=0, go to SEND.
- FSM SEND:
  - Dout/Vld/Sof/Eof are registered and held stable while Vld=1 and Rdy=0.
  - On Vld&Rdy at the edge, advance the index.
  - Nibble order for index 0..5: X[11:8], X[7:4], X[3:0], Y[11:8], Y[7:4], Y[3:0]. MSB first.
  - Sof=1 only at index 0. Eof=1 only at index 5.
  - Transfer at index 5 with FIFO non-empty: pop the next pair in the same edge and present its index 0 in the next cycle. Back-to-back frames have no idle gap.
  - Transfer at index 5 with FIFO empty: Vld=0, go to IDLE.
- Latency: a pair captured at edge t into an empty FIFO in IDLE has its first nibble valid in the cycle after edge t+1, i.e. 2 cycles after capture.
- Throughput:
  - Sustained 1 frame per 6 cycles with Rdy held high.
  - Sample pairs arriving faster than 1 per 6 cycles accumulate in the FIFO, then overflow.
- Rdy may toggle at any time. A nibble is transferred exactly once, only on a Vld&Rdy edge.
- Rdy is ignored while Vld=0.
- Capture and pop in the same cycle are independent. The count is unchanged when both occur.

Test Plan:
- Reset: rst=1 for 2 cycles with VldX=VldY=1 -> all outputs 0, no capture. After release, FIFO empty and Vld=0.
- Single pair, Rdy=1: inX=12'hA5C, inY=12'h3F1 for one cycle with both valids -> Vld rises 2 cycles later. Dout sequence is A,5,C,3,F,1 on consecutive cycles; Sof with A, Eof with 1; then Vld=0.
- Backpressure: same pair, Rdy=1,0,0,1,1,0,1,1,1 -> each nibble is held until its Rdy cycle; same 6-nibble order, no duplicate or skipped nibble.
- Overflow, DEPTH=4, Rdy=0: 6 consecutive captures (values 1..6 in inX) -> the first pair is held in the shift register, pairs 2-5 fill the FIFO, pair 6 is dropped and Ovf=1. With Rdy=1 afterwards, frames emerge with X=1..5, Ovf stays 1.
- Full with simultaneous pop: FIFO full, capture coincides with the Eof transfer -> the new pair is written and Ovf stays 0. The next frame starts without a gap.
- Sync error: VldX=1, VldY=0 for one cycle -> SyncErr=1, no frame produced. A subsequent valid pair is still serialized correctly.

Source files
------------

// File: rtl/nco_out_serializer.sv
// NCO output serializer: captures 12-bit X/Y sample pairs into a small FIFO and
// ships each pair as a 6-nibble frame (X MSB first, then Y) over a valid/ready pad bus.
module nco_out_serializer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned NW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          VldX,
    input  logic          VldY,
    input  logic [11:0]   inX,
    input  logic [11:0]   inY,
    input  logic          Rdy,
    output logic [NW-1:0] Dout,
    output logic          Vld,
    output logic          Sof,
    output logic          Eof,
    output logic          Ovf,
    output logic          SyncErr
);

    localparam int unsigned AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PW  = 24;       // bits per sample pair
    localparam int unsigned NPF = PW / NW;  // nibbles per frame

    typedef enum logic [0:0] {StIdle, StSend} state_t;

    logic [PW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;

    state_t        r_state;
    logic [2:0]    r_idx;
    logic [PW-1:0] r_shift;
    logic [NW-1:0] r_dout;
    logic          r_vld;
    logic          r_sof;
    logic          r_eof;
    logic          r_ovf;
    logic          r_syncerr;

    logic          w_empty;
    logic          w_full;
    logic          w_xfer;
    logic          w_last;
    logic          w_pop;
    logic          w_cap;
    logic          w_push;
    logic [PW-1:0] w_head;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == (AW+1)'(DEPTH));
    assign w_xfer  = r_vld & Rdy;
    assign w_last  = (r_idx == 3'(NPF - 1));
    // Pop when idle, or in the same edge as the final nibble's transfer (no gap)
    assign w_pop   = !w_empty && ((r_state == StIdle) || (w_xfer && w_last));
    assign w_cap   = VldX & VldY;
    // A simultaneous pop frees a slot, so a full FIFO can still accept
    assign w_push  = w_cap && (!w_full || w_pop);
    assign w_head  = r_mem[r_rptr];

    // FIFO storage; when full with push+pop, wptr==rptr and the pop reads the old entry
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {inX, inY};
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Frame FSM with registered pad outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_idx   <= '0;
            r_shift <= '0;
            r_dout  <= '0;
            r_vld   <= 1'b0;
            r_sof   <= 1'b0;
            r_eof   <= 1'b0;
        end else begin
            if (w_pop) begin
                r_state <= StSend;
                r_idx   <= '0;
                r_shift <= w_head;
                r_dout  <= w_head[PW-1 -: NW];
                r_vld   <= 1'b1;
                r_sof   <= 1'b1;
                r_eof   <= 1'b0;
            end else if (r_state == StSend && w_xfer) begin
                if (w_last) begin
                    r_state <= StIdle;
                    r_idx   <= '0;
                    r_dout  <= '0;
                    r_vld   <= 1'b0;
                    r_sof   <= 1'b0;
                    r_eof   <= 1'b0;
                end else begin
                    r_idx   <= r_idx + 3'd1;
                    r_shift <= {r_shift[PW-NW-1:0], {NW{1'b0}}};
                    r_dout  <= r_shift[PW-NW-1 -: NW];
                    r_sof   <= 1'b0;
                    r_eof   <= (r_idx == 3'(NPF - 2));
                end
            end
        end
    end

    // Sticky error flags, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf     <= 1'b0;
            r_syncerr <= 1'b0;
        end else begin
            if (w_cap && !w_push) r_ovf     <= 1'b1;
            if (VldX ^ VldY)      r_syncerr <= 1'b1;
        end
    end

    assign Dout    = r_dout;
    assign Vld     = r_vld;
    assign Sof     = r_sof;
    assign Eof     = r_eof;
    assign Ovf     = r_ovf;
    assign SyncErr = r_syncerr;

endmodule

// File: tb/tb_nco_out_serializer.sv
// Directed bench for nco_out_serializer: a queue-based frame model checked every
// cycle, plus literal expectations on captured nibble streams.
module tb_nco_out_serializer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        VldX = 1'b0;
    logic        VldY = 1'b0;
    logic [11:0] inX = '0;
    logic [11:0] inY = '0;
    logic        Rdy = 1'b0;
    logic [3:0]  Dout;
    logic        Vld;
    logic        Sof;
    logic        Eof;
    logic        Ovf;
    logic        SyncErr;

    nco_out_serializer #(.DEPTH(DEPTH), .NW(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .VldX    (VldX),
        .VldY    (VldY),
        .inX     (inX),
        .inY     (inY),
        .Rdy     (Rdy),
        .Dout    (Dout),
        .Vld     (Vld),
        .Sof     (Sof),
        .Eof     (Eof),
        .Ovf     (Ovf),
        .SyncErr (SyncErr)
    );

    always #5 clk = ~clk;

    int nchk  = 0;
    int npass = 0;

    // Model: pending pairs, the frame on the wire and its nibble position (-1 = none)
    logic [23:0] mq[$];
    logic [23:0] m_cur = '0;
    int          m_pos = -1;
    bit          m_ovf = 0;
    bit          m_se  = 0;

    logic [3:0]  xfer[$];  // nibbles accepted by the consumer

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_update(input bit r, input bit vx, input bit vy,
                                input logic [11:0] x, input logic [11:0] y, input bit rd);
        bit pop;
        pop = 0;
        if (r) begin
            mq.delete();
            m_pos = -1;
            m_ovf = 0;
            m_se  = 0;
            return;
        end
        if (m_pos < 0) begin
            if (mq.size() > 0) pop = 1;
        end else if (rd) begin
            if (m_pos == 5) begin
                if (mq.size() > 0) pop = 1;
                else m_pos = -1;
            end else begin
                m_pos++;
            end
        end
        if (pop) begin
            m_cur = mq.pop_front();
            m_pos = 0;
        end
        if (vx && vy) begin
            if (mq.size() < DEPTH) mq.push_back({x, y});
            else m_ovf = 1;
        end
        if (vx ^ vy) m_se = 1;
    endtask

    task automatic compare();
        logic [3:0] exp_n;
        chk("vld", {31'd0, Vld}, {31'd0, (m_pos >= 0)});
        chk("ovf", {31'd0, Ovf}, {31'd0, m_ovf});
        chk("syncerr", {31'd0, SyncErr}, {31'd0, m_se});
        if (m_pos >= 0) begin
            exp_n = 4'((m_cur >> (20 - 4 * m_pos)) & 24'hF);
            chk("dout", {28'd0, Dout}, {28'd0, exp_n});
            chk("sof", {31'd0, Sof}, {31'd0, (m_pos == 0)});
            chk("eof", {31'd0, Eof}, {31'd0, (m_pos == 5)});
        end
    endtask

    task automatic step(input bit r, input bit vx, input bit vy,
                        input logic [11:0] x, input logic [11:0] y, input bit rd);
        rst = r; VldX = vx; VldY = vy; inX = x; inY = y; Rdy = rd;
        #1;
        if (!r && Vld === 1'b1 && rd) xfer.push_back(Dout);
        @(posedge clk);
        model_update(r, vx, vy, x, y, rd);
        #1;
        compare();
    endtask

    task automatic idle(input int n, input bit rd);
        for (int i = 0; i < n; i++) step(0, 0, 0, 12'h0, 12'h0, rd);
    endtask

    // Compares six accepted nibbles starting at xfer[base] against literal X/Y
    task automatic chk_frame(input string name, input int base,
                             input logic [11:0] ex, input logic [11:0] ey);
        logic [23:0] w;
        logic [3:0]  got;
        w = {ex, ey};
        for (int i = 0; i < 6; i++) begin
            got = (base + i < xfer.size()) ? xfer[base + i] : 4'hx;
            chk(name, {28'd0, got}, {28'd0, w[23 - 4 * i -: 4]});
        end
    endtask

    initial begin
        bit pat[9];
        pat = '{1, 0, 0, 1, 1, 0, 1, 1, 1};

        // Reset with both valids high: nothing captured, all outputs low
        step(1, 1, 1, 12'hFFF, 12'hFFF, 1);
        step(1, 1, 1, 12'hFFF, 12'hFFF, 1);
        chk("rst_dout", {28'd0, Dout}, 32'd0);
        chk("rst_vld", {31'd0, Vld}, 32'd0);
        chk("rst_sof", {31'd0, Sof}, 32'd0);
        chk("rst_eof", {31'd0, Eof}, 32'd0);
        chk("rst_ovf", {31'd0, Ovf}, 32'd0);
        chk("rst_syncerr", {31'd0, SyncErr}, 32'd0);
        idle(3, 1);
        chk("post_rst_vld", {31'd0, Vld}, 32'd0);

        // Single pair with Rdy high: first nibble two cycles after capture
        xfer.delete();
        step(0, 1, 1, 12'hA5C, 12'h3F1, 1);
        chk("lat_vld_t1", {31'd0, Vld}, 32'd0);
        idle(1, 1);
        chk("lat_vld_t2", {31'd0, Vld}, 32'd1);
        chk("lat_sof", {31'd0, Sof}, 32'd1);
        chk("lat_dout", {28'd0, Dout}, 32'hA);
        idle(8, 1);
        chk("single_len", xfer.size(), 32'd6);
        chk_frame("single_frame", 0, 12'hA5C, 12'h3F1);
        chk("single_vld_end", {31'd0, Vld}, 32'd0);

        // Backpressure pattern
        xfer.delete();
        step(0, 1, 1, 12'hA5C, 12'h3F1, 1);
        idle(1, 1);
        for (int i = 0; i < 9; i++) idle(1, pat[i]);
        idle(3, 1);
        chk("bp_len", xfer.size(), 32'd6);
        chk_frame("bp_frame", 0, 12'hA5C, 12'h3F1);

        // Overflow: six captures with Rdy low, sixth dropped
        step(1, 0, 0, 12'h0, 12'h0, 0);
        xfer.delete();
        for (int k = 1; k <= 6; k++) step(0, 1, 1, 12'(k), 12'h0, 0);
        idle(1, 0);
        chk("ovf_set", {31'd0, Ovf}, 32'd1);
        idle(40, 1);
        chk("ovf_len", xfer.size(), 32'd30);
        for (int k = 0; k < 5; k++) chk_frame("ovf_frame", 6 * k, 12'(k + 1), 12'h0);
        chk("ovf_sticky", {31'd0, Ovf}, 32'd1);

        // Full FIFO, capture coinciding with the Eof transfer
        step(1, 0, 0, 12'h0, 12'h0, 0);
        for (int k = 1; k <= 5; k++) step(0, 1, 1, 12'h10 + 12'(k), 12'h0, 0);
        idle(1, 0);
        xfer.delete();
        idle(5, 1);
        chk("fp_eof_before", {31'd0, Eof}, 32'd1);
        step(0, 1, 1, 12'h066, 12'h777, 1);
        chk("fp_ovf", {31'd0, Ovf}, 32'd0);
        chk("fp_nogap_vld", {31'd0, Vld}, 32'd1);
        chk("fp_nogap_sof", {31'd0, Sof}, 32'd1);
        idle(40, 1);
        chk("fp_len", xfer.size(), 32'd36);
        chk_frame("fp_first", 0, 12'h011, 12'h0);
        chk_frame("fp_last", 30, 12'h066, 12'h777);

        // Sync error, then a good pair
        step(1, 0, 0, 12'h0, 12'h0, 1);
        step(0, 1, 0, 12'hBAD, 12'hBAD, 1);
        idle(5, 1);
        chk("se_flag", {31'd0, SyncErr}, 32'd1);
        chk("se_noframe", {31'd0, Vld}, 32'd0);
        xfer.delete();
        step(0, 1, 1, 12'h123, 12'h456, 1);
        idle(10, 1);
        chk("se_len", xfer.size(), 32'd6);
        chk_frame("se_frame", 0, 12'h123, 12'h456);
        chk("se_sticky", {31'd0, SyncErr}, 32'd1);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
